// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clkdiv_pkg
//  Purpose  : Shared constants for the rate-matched FIFO and its neighbours.
//             Holds the FIFO default geometry. It also holds the divide
//             ratios of the write/read rate clocks produced by the clock
//             divider, for use by benches.
//  Contents : FIFO_DW_DEF    - default FIFO data width (bits)
//             FIFO_DEPTH_DEF - default FIFO depth (entries, power of two)
//             WCLK_DIV       - clk / wclk ratio
//             RCLK_DIV       - clk / rclk ratio
//  Revision : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

   localparam int FIFO_DW_DEF    = 8;
   localparam int FIFO_DEPTH_DEF = 16;

   localparam int WCLK_DIV       = 2;
   localparam int RCLK_DIV       = 6;

endpackage : clkdiv_pkg
`default_nettype wire

// File: rtl/rise_strobe.sv
`default_nettype none
// ============================================================================
//  Module   : rise_strobe
//  Purpose  : Rising-edge detector for a slow, clk-generated level signal.
//             Produces a single-clk-wide strobe in the first cycle that din
//             is seen high after being low.
//  Ports    : clk   in  - master clock
//             rst_n in  - asynchronous active-low reset
//             din   in  - level to watch (already in the clk domain)
//             stb   out - one-cycle strobe on a 0->1 transition of din
//  Revision : 1.0 - initial release
// ============================================================================
module rise_strobe (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic stb
);

   logic r_din_q;

   // Reset to 0 so that a level already high when reset is released
   // counts as a rising edge in the first cycle out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_din_q <= 1'b0;
      end else begin
         r_din_q <= din;
      end
   end

   assign stb = din & ~r_din_q;

endmodule : rise_strobe
`default_nettype wire

// File: rtl/rate_matched_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rate_matched_fifo
//  Purpose  : Single-clock FIFO that runs on clk. The producer writes at the
//             wclk rate and the consumer reads at the rclk rate. wclk/rclk
//             come from a register-based divider on clk, so they are used
//             directly as rate strobes without synchronisers. Sticky
//             overflow/underflow flags record rejected requests.
//  Ports    : clk       in  - master clock
//             rst_n     in  - asynchronous active-low reset
//             wclk      in  - write-rate clock (clk/2)
//             rclk      in  - read-rate clock (clk/6)
//             wr_en     in  - write request, acted on at the next write strobe
//             wr_data   in  - write data, sampled in the write-strobe cycle
//             rd_en     in  - read request, acted on at the next read strobe
//             clr_err   in  - synchronous clear of overflow/underflow
//             rd_data   out - registered read data
//             rd_valid  out - one-clk pulse when rd_data has been updated
//             full      out - occupancy == DEPTH
//             empty     out - occupancy == 0
//             count     out - current occupancy
//             overflow  out - sticky: write requested while it could not fit
//             underflow out - sticky: read requested while empty
//  Revision : 1.0 - initial release
// ============================================================================
module rate_matched_fifo
   import clkdiv_pkg::*;
#(
   parameter int DW    = FIFO_DW_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wclk,
   input  logic                     rclk,
   input  logic                     wr_en,
   input  logic [DW-1:0]            wr_data,
   input  logic                     rd_en,
   input  logic                     clr_err,
   output logic [DW-1:0]            rd_data,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [AW:0]   c_full_count = (AW+1)'(DEPTH);
   localparam logic [AW:0]   c_cnt_one    = (AW+1)'(1);
   localparam logic [AW-1:0] c_ptr_one    = AW'(1);

   logic              w_wstb;
   logic              w_rstb;
   logic              w_wacc;
   logic              w_racc;
   logic              w_full;
   logic              w_empty;

   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_count;
   logic [DW-1:0]     r_rd_data;
   logic              r_rd_valid;
   logic              r_overflow;
   logic              r_underflow;
   logic [DW-1:0]     r_mem [DEPTH];

   // -------------------------------------------------------------------------
   // Rate strobes
   // -------------------------------------------------------------------------
   rise_strobe u_wstb (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (wclk),
      .stb   (w_wstb)
   );

   rise_strobe u_rstb (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (rclk),
      .stb   (w_rstb)
   );

   // -------------------------------------------------------------------------
   // Accept logic
   // -------------------------------------------------------------------------
   assign w_full  = (r_count == c_full_count);
   assign w_empty = (r_count == '0);

   // A read never sees the entry written in the same cycle, so an empty FIFO
   // rejects the read even when a write lands alongside it. A full FIFO can
   // take a write if a read frees a slot in the same cycle.
   assign w_racc  = w_rstb & rd_en & ~w_empty;
   assign w_wacc  = w_wstb & wr_en & (~w_full | w_racc);

   // -------------------------------------------------------------------------
   // Storage (no reset: contents are don't-care until written)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_wacc) begin
         r_mem[r_wptr] <= wr_data;
      end
   end

   // -------------------------------------------------------------------------
   // Pointers, occupancy, read port and sticky flags
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wacc) begin
            r_wptr <= r_wptr + c_ptr_one;
         end

         // On a simultaneous write and read of a full FIFO, wptr == rptr.
         // This reads the old entry before the write replaces it.
         if (w_racc) begin
            r_rd_data <= r_mem[r_rptr];
            r_rptr    <= r_rptr + c_ptr_one;
         end
         r_rd_valid <= w_racc;

         case ({w_wacc, w_racc})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase

         // A new error in the same cycle as clr_err keeps the flag set.
         if (w_wstb & wr_en & ~w_wacc) begin
            r_overflow <= 1'b1;
         end else if (clr_err) begin
            r_overflow <= 1'b0;
         end

         if (w_rstb & rd_en & w_empty) begin
            r_underflow <= 1'b1;
         end else if (clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign full      = w_full;
   assign empty     = w_empty;
   assign count     = r_count;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule : rate_matched_fifo
`default_nettype wire

// File: tb/tb_rate_matched_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rate_matched_fifo
//  Purpose  : Self-checking bench for rate_matched_fifo. Generates clk and a
//             register-based wclk (clk/2) / rclk (clk/6) divider. A queue
//             model of the FIFO is kept alongside directed stimulus, and
//             scenario-specific expected values are checked explicitly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rate_matched_fifo;
   import clkdiv_pkg::*;

   localparam int DW    = FIFO_DW_DEF;
   localparam int DEPTH = FIFO_DEPTH_DEF;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     wclk = 1'b0;
   logic                     rclk = 1'b0;
   logic                     wr_en;
   logic [DW-1:0]            wr_data;
   logic                     rd_en;
   logic                     clr_err;
   logic [DW-1:0]            rd_data;
   logic                     rd_valid;
   logic                     full;
   logic                     empty;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;
   logic                     underflow;

   rate_matched_fifo #(.DW(DW), .DEPTH(DEPTH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wclk      (wclk),
      .rclk      (rclk),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .clr_err   (clr_err),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   // Clock divider: wclk = clk/2, rclk = clk/6, both register outputs.
   int rdiv = 0;
   always @(posedge clk) begin
      wclk <= ~wclk;
      if (rdiv == (RCLK_DIV/2 - 1)) begin
         rdiv <= 0;
         rclk <= ~rclk;
      end else begin
         rdiv <= rdiv + 1;
      end
   end

   // Bench view of the previous divider levels, used to know which cycles
   // carry a rising edge.
   logic wclk_d, rclk_d;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wclk_d <= 1'b0;
         rclk_d <= 1'b0;
      end else begin
         wclk_d <= wclk;
         rclk_d <= rclk;
      end
   end

   int errors = 0;
   int checks = 0;

   // FIFO model
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_rd_data;
   logic          m_valid;
   logic          m_ovf;
   logic          m_udf;
   logic          m_wacc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_rd_data = '0;
      m_valid   = 1'b0;
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
      m_wacc    = 1'b0;
   endtask

   task automatic check_outputs();
      chk("count",     32'(count),     32'(m_q.size()));
      chk("empty",     32'(empty),     32'(m_q.size() == 0));
      chk("full",      32'(full),      32'(m_q.size() == DEPTH));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
      chk("rd_valid",  32'(rd_valid),  32'(m_valid));
      chk("rd_data",   32'(rd_data),   32'(m_rd_data));
   endtask

   // One clk cycle: check outputs at the falling edge, decide what the
   // coming rising edge will do, then update the model just after it.
   task automatic tick();
      logic          ws, rs, emp, racc_m, wacc_m, wen, ren, clr;
      logic [DW-1:0] wdat;
      @(negedge clk);
      check_outputs();
      ws     = wclk & ~wclk_d;
      rs     = rclk & ~rclk_d;
      emp    = (m_q.size() == 0);
      wen    = wr_en;
      ren    = rd_en;
      clr    = clr_err;
      wdat   = wr_data;
      racc_m = rst_n & rs & ren & ~emp;
      wacc_m = rst_n & ws & wen & ((m_q.size() < DEPTH) | racc_m);
      @(posedge clk);
      #1;
      if (rst_n) begin
         if (racc_m) m_rd_data = m_q.pop_front();
         m_valid = racc_m;
         if (wacc_m) m_q.push_back(wdat);
         m_ovf = (clr ? 1'b0 : m_ovf) | (ws & wen & ~wacc_m);
         m_udf = (clr ? 1'b0 : m_udf) | (rs & ren & emp);
         m_wacc = wacc_m;
      end
   endtask

   initial begin : stim
      int guard;
      int max_cnt;
      int n_rd;
      logic [DW-1:0] first_rd;

      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      model_reset();

      // ---- 1: reset and idle ------------------------------------------
      repeat (3) @(posedge clk);
      #1;
      chk("s1_rst_empty", 32'(empty), 32'd1);
      chk("s1_rst_count", 32'(count), 32'd0);
      rst_n = 1'b1;
      repeat (20) tick();
      chk("s1_idle_empty",    32'(empty),    32'd1);
      chk("s1_idle_full",     32'(full),     32'd0);
      chk("s1_idle_count",    32'(count),    32'd0);
      chk("s1_idle_rd_valid", 32'(rd_valid), 32'd0);

      // ---- 2: fill 0x00..0x0F, then overflow -------------------------------
      wr_en = 1'b1;
      wr_data = 8'h00;
      guard = 0;
      while (m_q.size() < DEPTH && guard < 200) begin
         tick();
         if (m_wacc) wr_data = wr_data + 8'h01;
         guard++;
      end
      chk("s2_full_count", 32'(count), 32'd16);
      chk("s2_full_flag",  32'(full),  32'd1);
      chk("s2_no_ovf_yet", 32'(overflow), 32'd0);
      guard = 0;
      while (!m_ovf && guard < 10) begin
         tick();
         guard++;
      end
      wr_en = 1'b0;
      chk("s2_overflow",   32'(overflow), 32'd1);
      chk("s2_count_hold", 32'(count),    32'd16);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("s2_ovf_cleared", 32'(overflow), 32'd0);

      // ---- 3: drain (0x00 first), then underflow -----------------------
      rd_en = 1'b1;
      guard = 0;
      n_rd = 0;
      first_rd = 8'hFF;
      while (m_q.size() > 0 && guard < 200) begin
         tick();
         if (rd_valid && n_rd == 0) first_rd = rd_data;
         if (rd_valid) n_rd++;
         guard++;
      end
      chk("s3_first_read", 32'(first_rd), 32'h00);
      chk("s3_drained",    32'(empty),    32'd1);
      guard = 0;
      while (!m_udf && guard < 20) begin
         tick();
         guard++;
      end
      rd_en = 1'b0;
      chk("s3_underflow", 32'(underflow), 32'd1);
      chk("s3_no_valid",  32'(rd_valid),  32'd0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("s3_udf_cleared", 32'(underflow), 32'd0);

      // ---- 4: continuous write+read from empty -------------------------
      wr_en = 1'b1;
      rd_en = 1'b1;
      wr_data = 8'h00;
      max_cnt = 0;
      n_rd = 0;
      first_rd = 8'hFF;
      repeat (200) begin
         tick();
         if (m_wacc) wr_data = wr_data + 8'h01;
         if (int'(count) > max_cnt) max_cnt = int'(count);
         if (rd_valid && n_rd == 0) first_rd = rd_data;
         if (rd_valid) n_rd++;
      end
      chk("s4_first_read", 32'(first_rd), 32'h00);
      chk("s4_max_count",  32'(max_cnt),  32'd16);
      chk("s4_overflow",   32'(overflow), 32'd1);
      wr_en = 1'b0;
      guard = 0;
      while (m_q.size() > 0 && guard < 300) begin
         tick();
         guard++;
      end
      rd_en = 1'b0;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("s4_drained", 32'(count), 32'd0);

      // ---- 5: 40 fill/drain rounds with random data -------------------
      for (int r = 0; r < 40; r++) begin
         wr_en = 1'b1;
         wr_data = 8'($urandom_range(0, 255));
         guard = 0;
         while (m_q.size() < DEPTH && guard < 200) begin
            tick();
            if (m_wacc) wr_data = 8'($urandom_range(0, 255));
            guard++;
         end
         wr_en = 1'b0;
         rd_en = 1'b1;
         guard = 0;
         while (m_q.size() > 0 && guard < 300) begin
            tick();
            guard++;
         end
         rd_en = 1'b0;
      end
      tick();
      chk("s5_end_empty", 32'(empty), 32'd1);
      chk("s5_no_udf",    32'(underflow), 32'd0);

      // ---- 6: reset at count=9 -----------------------------------------
      wr_en = 1'b1;
      wr_data = 8'h30;
      guard = 0;
      while (m_q.size() < 9 && guard < 100) begin
         tick();
         if (m_wacc) wr_data = wr_data + 8'h01;
         guard++;
      end
      wr_en = 1'b0;
      chk("s6_pre_count", 32'(count), 32'd9);
      rst_n = 1'b0;
      #1;
      chk("s6_rst_count", 32'(count),     32'd0);
      chk("s6_rst_empty", 32'(empty),     32'd1);
      chk("s6_rst_ovf",   32'(overflow),  32'd0);
      chk("s6_rst_udf",   32'(underflow), 32'd0);
      model_reset();
      tick();
      rst_n = 1'b1;
      wr_data = 8'hA5;
      wr_en = 1'b1;
      guard = 0;
      while (!m_wacc && guard < 10) begin
         tick();
         guard++;
      end
      wr_en = 1'b0;
      rd_en = 1'b1;
      guard = 0;
      while (!m_valid && guard < 20) begin
         tick();
         guard++;
      end
      rd_en = 1'b0;
      chk("s6_first_valid", 32'(rd_valid), 32'd1);
      chk("s6_first_entry", 32'(rd_data),  32'hA5);
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_rate_matched_fifo
`default_nettype wire
